// File: rtl/fetch_unit.sv
// Pipelined instruction fetcher: credit-limited requests, prefetch FIFO, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET = 32'h00000000,
    parameter int          DEPTH = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_redirect,
    input  logic [31:0] I_target,
    output logic        O_mem_req,
    output logic [31:0] O_mem_addr,
    input  logic        I_mem_gnt,
    input  logic        I_mem_rvalid,
    input  logic [31:0] I_mem_rdata,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [31:0] O_inst,
    output logic [31:0] O_pc
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_pc_q   [DEPTH];
    logic [31:0]   r_inst_q [DEPTH];
    logic [31:0]   r_tag_q  [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_tag_wptr;
    logic [AW-1:0] r_tag_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_disc;
    logic [31:0]   r_hold_pc;
    logic [31:0]   r_hold_inst;

    logic          w_empty;
    logic          w_grant;
    logic          w_accept;
    logic          w_byp;
    logic          w_push;
    logic          w_pop;
    logic          w_stale;
    logic [CW:0]   w_credit;
    logic [31:0]   w_tag;
    logic          w_unused;

    assign w_unused   = ^I_target[1:0];
    assign w_empty    = (r_count == '0);
    assign w_credit   = {1'b0, r_count} + {1'b0, r_outst};
    assign O_mem_req  = !I_rst && !I_redirect && (w_credit < (CW+1)'(DEPTH));
    assign O_mem_addr = r_fetch_pc;
    assign w_grant    = O_mem_req && I_mem_gnt;
    assign w_accept   = I_mem_rvalid && (r_disc == '0) && !I_redirect;
    assign w_stale    = I_mem_rvalid && (r_disc != '0);
    assign w_tag      = r_tag_q[r_tag_rptr];

`ifdef FETCH_BYPASS_EN
    assign w_byp = w_empty && w_accept;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed word taken by decode this cycle never enters the FIFO
    assign w_push  = w_accept && !(w_byp && I_ready);
    assign w_pop   = !w_empty && I_ready && !I_redirect;
    assign O_valid = !I_redirect && (!w_empty || w_byp);

    always_comb begin
        O_pc   = r_hold_pc;
        O_inst = r_hold_inst;
        if (!w_empty) begin
            O_pc   = r_pc_q[r_rptr];
            O_inst = r_inst_q[r_rptr];
        end else if (w_byp) begin
            O_pc   = w_tag;
            O_inst = I_mem_rdata;
        end
    end

    always_ff @(posedge I_clk) begin
        if (w_grant) begin
            r_tag_q[r_tag_wptr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_pc_q[r_wptr]   <= w_tag;
            r_inst_q[r_wptr] <= I_mem_rdata;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_fetch_pc  <= RESET;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_tag_wptr  <= '0;
            r_tag_rptr  <= '0;
            r_count     <= '0;
            r_outst     <= '0;
            r_disc      <= '0;
            r_hold_pc   <= RESET;
            r_hold_inst <= NOP;
        end else begin
            r_hold_pc   <= O_pc;
            r_hold_inst <= O_inst;
            if (I_redirect) begin
                // Everything in flight becomes stale, including a response landing now
                r_fetch_pc <= {I_target[31:2], 2'b00};
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_tag_wptr <= '0;
                r_tag_rptr <= '0;
                r_count    <= '0;
                r_outst    <= '0;
                r_disc     <= r_disc + r_outst - CW'(I_mem_rvalid);
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tag_wptr <= r_tag_wptr + AW'(1);
                end
                if (w_accept) begin
                    r_tag_rptr <= r_tag_rptr + AW'(1);
                end
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                r_outst <= r_outst + CW'(w_grant) - CW'(w_accept);
                r_disc  <= r_disc - CW'(w_stale);
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RV32E core: it replaces the direct PC-to-instruction-memory path with a pipelined request/response fetcher and a prefetch FIFO. It keeps up to DEPTH fetches in flight or buffered, presents {PC, instruction} pairs to decode under a valid/ready handshake, and flushes cleanly on a branch/jump redirect from the PCSel path. It sits between the PC mux and decode; memory latency can be variable but responses are in order.

## Interface
- RESET, 32'h00000000, fetch address loaded on reset
- DEPTH, 4, prefetch FIFO entries and maximum in-flight plus buffered fetches; power of two, at least 2
- I_clk  in  1  clock
- I_rst  in  1  reset, asynchronous, active-high
- I_redirect  in  1  take branch/jump this cycle (PCSel)
- I_target  in  32  redirect address; bits [1:0] ignored, forced to 00
- O_mem_req  out  1  fetch request
- O_mem_addr  out  32  word-aligned fetch address
- I_mem_gnt  in  1  request accepted when O_mem_req && I_mem_gnt
- I_mem_rvalid  in  1  response valid; in order, at least 1 cycle after its grant
- I_mem_rdata  in  32  response instruction word
- O_valid  out  1  O_inst/O_pc valid
- I_ready  in  1  decode accepts; transfer when O_valid && I_ready
- O_inst  out  32  instruction word
- O_pc  out  32  address of O_inst

## Operation
- State: fetch_pc (32 bits), FIFO of {pc, inst} with DEPTH entries, outstanding counter, discard counter, pc-tag FIFO for in-flight requests. Both counters are clog2(DEPTH+1) bits.
- Credit rule: O_mem_req = !I_rst && !I_redirect && (occupancy + outstanding) < DEPTH. The FIFO therefore can never overflow.
- Grant: fetch_pc += 4, wrapping modulo 2^32. outstanding += 1. The issued address is tagged for its response.
- Response with discard == 0 and no redirect: push {tag, I_mem_rdata}, outstanding -= 1.
- Response with discard > 0: dropped, discard -= 1.
- Redirect cycle:
  - fetch_pc <= {I_target[31:2], 2'b00}.
  - FIFO is emptied.
  - discard <= discard + outstanding − (I_mem_rvalid ? 1 : 0). Any response arriving this cycle is dropped.
  - outstanding <= 0.
  - O_valid and O_mem_req are forced 0, so no pop and no grant occur.
- Pop: O_valid && I_ready && !I_redirect. Push and pop in the same cycle leave occupancy unchanged.
- Empty: O_valid = 0, and O_inst/O_pc hold their last value.
- Requests after a redirect are allowed while discard > 0. Their responses are accepted only after all stale responses have drained.

## Timing
- Reset values (async):
  - O_mem_req = 0, O_valid = 0.
  - O_mem_addr = RESET, O_pc = RESET, O_inst = 32'h00000013 (NOP).
  - fetch_pc = RESET, all counters 0, FIFO empty.
- Reset mid-operation: everything in flight is abandoned. The memory must also be reset, because no discard state survives reset.
- First request: O_mem_req rises in the first cycle after I_rst deasserts, with O_mem_addr = RESET.
- Latency without bypass: grant at cycle t, response at t+L, O_valid at t+L+1.
- Throughput: one instruction per cycle with grant always high, fixed L, and I_ready held high, provided DEPTH > L.
- Redirect at cycle r: O_mem_req = 1 with O_mem_addr = target at r+1. The first new instruction is visible no earlier than r+1+L+1.
- O_mem_addr is combinational from fetch_pc. All other outputs come from registers, except the redirect forcing and, when enabled, the bypass.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty, a response is accepted, and there is no redirect, O_valid/O_inst/O_pc drive the response combinationally in the same cycle.
  - If I_ready is high, the word is consumed and not pushed.
  - If I_ready is low, it is pushed as normal.
  - Latency becomes t+L.
- FETCH_BYPASS_EN undefined: every response is pushed first, and outputs come from the FIFO head only.

## Test plan
- Reset release with RESET=32'h00000100, gnt=1, L=1, ready=1:
  - Requests go out to 0x100, 0x104, 0x108, and so on.
  - O_pc sequence is 0x100, 0x104, 0x108 with one instruction per cycle after the fill latency.
- Backpressure with I_ready=0 and DEPTH=4:
  - Exactly 4 grants occur, then O_mem_req=0 and the FIFO is full.
  - Raising ready drains 4 entries in order, and requests resume.
- Redirect with 2 outstanding and 1 buffered, I_target=32'h00000203:
  - FIFO flushed, and the next request goes to 0x200.
  - The 2 stale responses are dropped; O_pc's first value afterwards is 0x200.
- Redirect coinciding with I_mem_rvalid and I_ready:
  - The response is dropped and no pop is counted.
  - discard equals the prior outstanding count minus 1.
- Address wrap: redirect to 32'hFFFFFFFC produces O_pc 0xFFFFFFFC followed by 0x00000000.
- FETCH_BYPASS_EN, empty FIFO, L=2, ready=1:
  - O_valid asserts in the same cycle as I_mem_rvalid, with O_inst equal to I_mem_rdata.
  - Without the macro, O_valid asserts one cycle later.
